mux3_bus_arbiter: RTL

//   Round-robin arbiter/sequencer for the shared 32-bit 3:1 select mux (sel 00/01/10 -> src0/1/2, 11 -> 32'h0).

---
 rtl/mux3_bus_arbiter_if.sv | 23 ++
 rtl/mux3_bus_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/mux3_bus_arbiter_if.sv
// Handshake bundle between three burst requesters, the arbiter and the shared
// result bus. slave = arbiter view, master = requester/downstream view.
interface mux3_bus_arbiter_if;
  logic [2:0] req_valid;
  logic [2:0] req_last;
  logic [2:0] req_ready;
  logic [1:0] mux_sel;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [2:0] grant;
  logic       limit_err;

  modport slave (
    input  req_valid, req_last, out_ready,
    output req_ready, mux_sel, out_valid, out_last, grant, limit_err
  );

  modport master (
    output req_valid, req_last, out_ready,
    input  req_ready, mux_sel, out_valid, out_last, grant, limit_err
  );
endinterface

// File: rtl/mux3_bus_arbiter.sv
// Round-robin owner selection for the shared 3:1 result mux; holds the owner for
// a whole burst and releases on last beat or after MAX_BEATS accepted beats.
module mux3_bus_arbiter #(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input  logic               clk,
  input  logic               reset,
  mux3_bus_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [1:0]       rr_ptr;
  logic [2:0]       grant_q;
  logic [1:0]       sel_q;
  logic             err_q;

  logic             busy;
  logic [3:0]       vld_ext;
  logic [3:0]       last_ext;
  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit_limit;
  logic             release_burst;
  logic             pick_vld;
  logic [1:0]       pick;

  // sel_q is 11 while idle, so pad the per-requester vectors to a 4-entry table
  assign busy     = (state == BUSY);
  assign vld_ext  = {1'b0, bus.req_valid};
  assign last_ext = {1'b0, bus.req_last};

  assign bus.out_valid = busy & vld_ext[sel_q];
  assign bus.out_last  = busy & last_ext[sel_q];
  assign bus.req_ready = (busy && bus.out_ready) ? grant_q : 3'b000;
  assign bus.grant     = grant_q;
  assign bus.mux_sel   = sel_q;
  assign bus.limit_err = err_q;

  assign accept        = bus.out_valid & bus.out_ready;
  assign cnt_inc       = beat_cnt + 1'b1;
  assign hit_limit     = (cnt_inc == CNT_W'(MAX_BEATS));
  assign release_burst = accept & (bus.out_last | hit_limit);

  // Scan rr_ptr+1, +2, +3; iterating backwards lets the nearest requester win.
  always_comb begin
    pick_vld = 1'b0;
    pick     = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      automatic int idx = (int'(rr_ptr) + k) % 3;
      if (bus.req_valid[idx]) begin
        pick_vld = 1'b1;
        pick     = 2'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant_q  <= 3'b000;
      sel_q    <= 2'b11;
      beat_cnt <= '0;
      rr_ptr   <= 2'd2;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state    <= BUSY;
            grant_q  <= 3'b001 << pick;
            sel_q    <= pick;
            beat_cnt <= '0;
          end
        end
        BUSY: begin
          if (release_burst) begin
            state    <= IDLE;
            grant_q  <= 3'b000;
            sel_q    <= 2'b11;
            beat_cnt <= '0;
            rr_ptr   <= sel_q;
            err_q    <= hit_limit & ~bus.out_last;
          end else if (accept) begin
            beat_cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
